// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle: {pc, inst} in from fetch, out to decode.
// master = fetch/decode side driving data and out_ready; slave = the queue.
interface fetch_decode_queue_if #(
  parameter int PC_W   = 16,
  parameter int INST_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry elastic FIFO between fetch and decode with flush and bubbles.
// Define FDQ_BYPASS_EN for a zero-latency path through an empty queue.
module fetch_decode_queue #(
  parameter int PC_W   = 16,
  parameter int INST_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  fetch_decode_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              empty;
  logic              push;
  logic              pop;
  logic              byp;

  assign empty       = (count == '0);
  assign bus.in_ready = (count != FULL);

  always_comb begin
    byp          = 1'b0;
    bus.out_valid = ~empty & ~flush;
    bus.out_pc    = '0;
    bus.out_inst  = '0;
    if (bus.out_valid) begin
      bus.out_pc   = mem_pc[rd_ptr];
      bus.out_inst = mem_inst[rd_ptr];
    end
`ifdef FDQ_BYPASS_EN
    // Empty queue forwards fetch straight to decode.
    if (empty && !flush) begin
      byp           = 1'b1;
      bus.out_valid = bus.in_valid;
      if (bus.in_valid) begin
        bus.out_pc   = bus.in_pc;
        bus.out_inst = bus.in_inst;
      end
    end
`endif
  end

  assign push = bus.in_valid & bus.in_ready & ~flush
              & ~(byp & bus.out_ready);
  assign pop  = bus.out_valid & bus.out_ready & ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= bus.in_pc;
      mem_inst[wr_ptr] <= bus.in_inst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed-vector bench for fetch_decode_queue (DEPTH=4, 16-bit pc/inst).
// Bypass-specific checks are built only with FDQ_BYPASS_EN.
module tb_fetch_decode_queue;
  localparam int PC_W = 16, INST_W = 16, DEPTH = 4, AW = 2;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] ipc;
    logic [15:0] iinst;
    logic        ordy;
    logic        eov;
    logic [15:0] epc;
    logic [15:0] einst;
    logic [AW:0] ecnt;
    logic        eir;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [AW:0] count;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs[$];
  logic [31:0] sb[$];

  fetch_decode_queue_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  fetch_decode_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic fl, logic iv, logic [15:0] ipc,
                              logic [15:0] iinst, logic ordy, logic eov,
                              logic [15:0] epc, logic [15:0] einst,
                              logic [AW:0] ecnt, logic eir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ipc = ipc; v.iinst = iinst; v.ordy = ordy;
    v.eov = eov; v.epc = epc; v.einst = einst; v.ecnt = ecnt; v.eir = eir;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic iv, logic [15:0] pc,
                       logic [15:0] inst, logic ordy);
    @(negedge clk);
    flush = fl; bus.in_valid = iv; bus.in_pc = pc;
    bus.in_inst = inst; bus.out_ready = ordy;
    #1;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 0;

    // fl iv pc inst ordy | ov pc inst cnt ir
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0, 0,16'h0000,16'h0000,0,1));
    vecs.push_back(mk(0,0,16'h1234,16'h5678,1, 0,16'h0000,16'h0000,0,1));
    vecs.push_back(mk(0,1,16'h0010,16'hA000,0, 0,16'h0000,16'h0000,0,1));
    vecs.push_back(mk(0,1,16'h0011,16'hA001,0, 1,16'h0010,16'hA000,1,1));
    vecs.push_back(mk(0,1,16'h0012,16'hA002,0, 1,16'h0010,16'hA000,2,1));
    vecs.push_back(mk(0,1,16'h0013,16'hA003,0, 1,16'h0010,16'hA000,3,1));
    vecs.push_back(mk(0,1,16'h0014,16'hA004,0, 1,16'h0010,16'hA000,4,0));
    vecs.push_back(mk(0,1,16'h0014,16'hA004,0, 1,16'h0010,16'hA000,4,0));
    vecs.push_back(mk(0,1,16'h0014,16'hA004,1, 1,16'h0010,16'hA000,4,0));
    vecs.push_back(mk(0,1,16'h0014,16'hA004,1, 1,16'h0011,16'hA001,3,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 1,16'h0012,16'hA002,3,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 1,16'h0013,16'hA003,2,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 1,16'h0014,16'hA004,1,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 0,16'h0000,16'h0000,0,1));
    vecs.push_back(mk(0,1,16'h0020,16'hB000,0, 0,16'h0000,16'h0000,0,1));
    vecs.push_back(mk(0,1,16'h0021,16'hB001,0, 1,16'h0020,16'hB000,1,1));
    vecs.push_back(mk(0,1,16'h0022,16'hB002,0, 1,16'h0020,16'hB000,2,1));
    vecs.push_back(mk(1,1,16'h0030,16'hBEEF,1, 0,16'h0000,16'h0000,3,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 0,16'h0000,16'h0000,0,1));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1, 0,16'h0000,16'h0000,0,1));

    #1;
    chk("reset_state", {bus.out_valid, bus.out_pc, bus.out_inst, count,
                        bus.in_ready},
        {1'b0, 16'h0, 16'h0, 3'd0, 1'b1});
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
`ifdef FDQ_BYPASS_EN
      if (v.ecnt == 0 && !v.fl) begin
        v.eov = v.iv;
        v.epc = v.iv ? v.ipc : 16'h0;
        v.einst = v.iv ? v.iinst : 16'h0;
      end
`endif
      drive(v.fl, v.iv, v.ipc, v.iinst, v.ordy);
      chk($sformatf("vec%0d", i),
          {bus.out_valid, bus.out_pc, bus.out_inst, count, bus.in_ready},
          {v.eov, v.epc, v.einst, v.ecnt, v.eir});
      if (bus.out_inst == 16'hBEEF) chk("beef_leak", 1, 0);
    end

    // Concurrent push/pop at count=2, streaming 10 entries across the wrap
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 16'h0040 + 16'(i), 16'hD000 + 16'(i), 0);
      sb.push_back({16'h0040 + 16'(i), 16'hD000 + 16'(i)});
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 16'h0042 + 16'(k), 16'hD002 + 16'(k), 1);
      chk("pp_count", count, 2);
      chk("pp_head", {bus.out_valid, bus.out_pc, bus.out_inst},
          {1'b1, sb[0]});
      void'(sb.pop_front());
      sb.push_back({16'h0042 + 16'(k), 16'hD002 + 16'(k)});
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 16'h0, 16'h0, 1);
      if (!bus.out_valid) break;
      chk("drain_head", {bus.out_pc, bus.out_inst}, sb[0]);
      void'(sb.pop_front());
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_cnt", {bus.out_valid, count}, {1'b0, 3'd0});

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) drive(0, 1, 16'h60, 16'hE000, 0);
    drive(0, 0, 16'h0, 16'h0, 0);
    chk("pre_reset_cnt", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {bus.out_valid, bus.out_inst, count, bus.in_ready},
        {1'b0, 16'h0, 3'd0, 1'b1});
    @(negedge clk);
    reset = 1'b1;

    // Flush held over several cycles with fetch still pushing
    drive(0, 1, 16'h70, 16'hF000, 0);
    drive(0, 1, 16'h71, 16'hF001, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 16'h72, 16'hF002, 1);
      chk("flush_hold_ov", bus.out_valid, 0);
      if (k > 0) chk("flush_hold_cnt", count, 0);
    end
    drive(0, 0, 16'h0, 16'h0, 1);
    chk("after_flush", {bus.out_valid, bus.out_inst, count},
        {1'b0, 16'h0, 3'd0});

`ifdef FDQ_BYPASS_EN
    drive(0, 1, 16'h0080, 16'hC001, 1);
    chk("byp_same", {bus.out_valid, bus.out_inst, count},
        {1'b1, 16'hC001, 3'd0});
    drive(0, 0, 16'h0, 16'h0, 1);
    chk("byp_consumed", {bus.out_valid, count}, {1'b0, 3'd0});
    drive(0, 1, 16'h0080, 16'hC001, 0);
    chk("byp_stall", {bus.out_valid, bus.out_inst, count},
        {1'b1, 16'hC001, 3'd0});
    drive(0, 0, 16'h0, 16'h0, 1);
    chk("byp_written", {bus.out_valid, bus.out_inst, count},
        {1'b1, 16'hC001, 3'd1});
    drive(0, 0, 16'h0, 16'h0, 1);
    chk("byp_drained", {bus.out_valid, count}, {1'b0, 3'd0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
